// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline boundary: bus widths, stall
// vector layout, write-enable literals and the stage update decision helper.
package mem_wb_stage_pkg;

   localparam int StallVecW   = 6;
   localparam int STALL_MEM   = 4;
   localparam int STALL_WB    = 5;

   localparam int RegAddrBusW = 5;
   localparam int RegBusW     = 32;
   localparam int RegNum      = 32;
   localparam int Cp0AddrW    = 5;

   localparam logic [RegBusW-1:0] ZeroWord = 32'h0000_0000;

   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic RstEnable    = 1'b1;

   // What the WB pipeline register does on a given rising edge.
   typedef enum logic [1:0] {
      WB_BUBBLE = 2'd0,
      WB_LOAD   = 2'd1,
      WB_HOLD   = 2'd2
   } wb_action_e;

   // Flush wins over everything; a stalled MEM feeding a running WB must
   // insert a bubble so the stalled instruction is not committed twice.
   // A non-monotone vector (MEM running, WB stalled) is treated as a load.
   function automatic wb_action_e wb_action(input logic flush,
                                            input logic [StallVecW-1:0] stall);
      wb_action_e act;
      if (flush)
         act = WB_BUBBLE;
      else if (!stall[STALL_MEM])
         act = WB_LOAD;
      else if (!stall[STALL_WB])
         act = WB_BUBBLE;
      else
         act = WB_HOLD;
      return act;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bus: mem_* fields are produced by the MEM stage, wb_* fields are
// the registered write ports toward the register file, HI/LO, LLbit and CP0.
interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic [RegAddrBusW-1:0] mem_wd;
   logic                   mem_wreg;
   logic [RegBusW-1:0]     mem_wdata;
   logic                   mem_whilo;
   logic [RegBusW-1:0]     mem_hi;
   logic [RegBusW-1:0]     mem_lo;
   logic                   mem_llbit_we;
   logic                   mem_llbit_value;
   logic                   mem_cp0_we;
   logic [Cp0AddrW-1:0]    mem_cp0_waddr;
   logic [RegBusW-1:0]     mem_cp0_wdata;

   logic [RegAddrBusW-1:0] wb_wd;
   logic                   wb_wreg;
   logic [RegBusW-1:0]     wb_wdata;
   logic                   wb_whilo;
   logic [RegBusW-1:0]     wb_hi;
   logic [RegBusW-1:0]     wb_lo;
   logic                   wb_llbit_we;
   logic                   wb_llbit_value;
   logic                   wb_cp0_we;
   logic [Cp0AddrW-1:0]    wb_cp0_waddr;
   logic [RegBusW-1:0]     wb_cp0_wdata;

   modport master (
      output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_llbit_we, mem_llbit_value, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
      input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
             wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata
   );

   modport slave (
      input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
             mem_llbit_we, mem_llbit_value, mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
      output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
             wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata
   );

endinterface

// File: rtl/mem_wb_stage_llbit_reg.sv
// LLbit register for LL/SC. An exception flush breaks any pending LL/SC
// sequence, so it clears the bit with priority over a committed write.
module llbit_reg
   import mem_wb_stage_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic we,
   input  logic din,
   output logic dout
);

   // Clear on reset or flush, otherwise take the committed WB update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable)
         dout <= 1'b0;
      else if (flush)
         dout <= 1'b0;
      else if (we == WriteEnable)
         dout <= din;
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the 5-stage MIPS32 core. Registers the GPR,
// HI/LO, LLbit and CP0 write ports and owns the architectural LLbit.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int REG_ADDR_W = RegAddrBusW,
   parameter int DATA_W     = RegBusW,
   parameter int CP0_ADDR_W = Cp0AddrW
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [StallVecW-1:0] stall,
   input  logic                 flush,
   mem_wb_stage_if.slave        bus,
   output logic                 llbit_o
);

   logic [REG_ADDR_W-1:0] wd_q;
   logic                  wreg_q;
   logic [DATA_W-1:0]     wdata_q;
   logic                  whilo_q;
   logic [DATA_W-1:0]     hi_q;
   logic [DATA_W-1:0]     lo_q;
   logic                  llbit_we_q;
   logic                  llbit_value_q;
   logic                  cp0_we_q;
   logic [CP0_ADDR_W-1:0] cp0_waddr_q;
   logic [DATA_W-1:0]     cp0_wdata_q;

   wb_action_e action;

   assign action = wb_action(flush, stall);

   // Pipeline register: bubble, load from MEM, or hold, as decided above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         wd_q          <= '0;
         wreg_q        <= WriteDisable;
         wdata_q       <= '0;
         whilo_q       <= WriteDisable;
         hi_q          <= '0;
         lo_q          <= '0;
         llbit_we_q    <= WriteDisable;
         llbit_value_q <= 1'b0;
         cp0_we_q      <= WriteDisable;
         cp0_waddr_q   <= '0;
         cp0_wdata_q   <= '0;
      end else begin
         case (action)
            WB_LOAD: begin
               wd_q          <= bus.mem_wd;
               wreg_q        <= bus.mem_wreg;
               wdata_q       <= bus.mem_wdata;
               whilo_q       <= bus.mem_whilo;
               hi_q          <= bus.mem_hi;
               lo_q          <= bus.mem_lo;
               llbit_we_q    <= bus.mem_llbit_we;
               llbit_value_q <= bus.mem_llbit_value;
               cp0_we_q      <= bus.mem_cp0_we;
               cp0_waddr_q   <= bus.mem_cp0_waddr;
               cp0_wdata_q   <= bus.mem_cp0_wdata;
            end
            WB_HOLD: begin
               wd_q          <= wd_q;
               wreg_q        <= wreg_q;
               wdata_q       <= wdata_q;
               whilo_q       <= whilo_q;
               hi_q          <= hi_q;
               lo_q          <= lo_q;
               llbit_we_q    <= llbit_we_q;
               llbit_value_q <= llbit_value_q;
               cp0_we_q      <= cp0_we_q;
               cp0_waddr_q   <= cp0_waddr_q;
               cp0_wdata_q   <= cp0_wdata_q;
            end
            default: begin
               wd_q          <= '0;
               wreg_q        <= WriteDisable;
               wdata_q       <= '0;
               whilo_q       <= WriteDisable;
               hi_q          <= '0;
               lo_q          <= '0;
               llbit_we_q    <= WriteDisable;
               llbit_value_q <= 1'b0;
               cp0_we_q      <= WriteDisable;
               cp0_waddr_q   <= '0;
               cp0_wdata_q   <= '0;
            end
         endcase
      end
   end

   assign bus.wb_wd          = wd_q;
   assign bus.wb_wreg        = wreg_q;
   assign bus.wb_wdata       = wdata_q;
   assign bus.wb_whilo       = whilo_q;
   assign bus.wb_hi          = hi_q;
   assign bus.wb_lo          = lo_q;
   assign bus.wb_llbit_we    = llbit_we_q;
   assign bus.wb_llbit_value = llbit_value_q;
   assign bus.wb_cp0_we      = cp0_we_q;
   assign bus.wb_cp0_waddr   = cp0_waddr_q;
   assign bus.wb_cp0_wdata   = cp0_wdata_q;

   llbit_reg u_llbit_reg (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .we    (llbit_we_q),
      .din   (llbit_value_q),
      .dout  (llbit_o)
   );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: reset, capture, bubble/hold, flush
// priority, LL/SC sequencing, $0 pass-through, CP0 and mid-run reset.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic       clk;
   logic       rst;
   logic [5:0] stall;
   logic       flush;
   logic       llbit_o;

   int vec_count;
   int miss_count;

   logic [31:0] tb_rf [0:31];

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush   (flush),
      .bus     (bus),
      .llbit_o (llbit_o)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Small register-file model fed by the WB write port; $0 is never written.
   always @(posedge clk) begin
      if (bus.wb_wreg && bus.wb_wd != 5'd0)
         tb_rf[bus.wb_wd] <= bus.wb_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vec_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkWb(input string tag,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                          input logic llwe, input logic llval,
                          input logic cp0we, input logic [4:0] cp0addr, input logic [31:0] cp0data,
                          input logic llbit);
      checkOutput({tag, ".wb_wd"},          32'(bus.wb_wd),          32'(wd));
      checkOutput({tag, ".wb_wreg"},        32'(bus.wb_wreg),        32'(wreg));
      checkOutput({tag, ".wb_wdata"},       bus.wb_wdata,            wdata);
      checkOutput({tag, ".wb_whilo"},       32'(bus.wb_whilo),       32'(whilo));
      checkOutput({tag, ".wb_hi"},          bus.wb_hi,               hi);
      checkOutput({tag, ".wb_lo"},          bus.wb_lo,               lo);
      checkOutput({tag, ".wb_llbit_we"},    32'(bus.wb_llbit_we),    32'(llwe));
      checkOutput({tag, ".wb_llbit_value"}, 32'(bus.wb_llbit_value), 32'(llval));
      checkOutput({tag, ".wb_cp0_we"},      32'(bus.wb_cp0_we),      32'(cp0we));
      checkOutput({tag, ".wb_cp0_waddr"},   32'(bus.wb_cp0_waddr),   32'(cp0addr));
      checkOutput({tag, ".wb_cp0_wdata"},   bus.wb_cp0_wdata,        cp0data);
      checkOutput({tag, ".llbit_o"},        32'(llbit_o),            32'(llbit));
   endtask

   task automatic setInputs(input logic [5:0] st, input logic fl,
                            input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                            input logic llwe, input logic llval,
                            input logic cp0we, input logic [4:0] cp0addr, input logic [31:0] cp0data);
      stall                  = st;
      flush                  = fl;
      bus.mem_wd             = wd;
      bus.mem_wreg           = wreg;
      bus.mem_wdata          = wdata;
      bus.mem_whilo          = whilo;
      bus.mem_hi             = hi;
      bus.mem_lo             = lo;
      bus.mem_llbit_we       = llwe;
      bus.mem_llbit_value    = llval;
      bus.mem_cp0_we         = cp0we;
      bus.mem_cp0_waddr      = cp0addr;
      bus.mem_cp0_wdata      = cp0data;
   endtask

   // Drive one set of MEM-side inputs, then advance one rising edge and
   // settle 1 unit past it so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic [5:0] st, input logic fl,
                                input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                                input logic llwe, input logic llval,
                                input logic cp0we, input logic [4:0] cp0addr, input logic [31:0] cp0data);
      setInputs(st, fl, wd, wreg, wdata, whilo, hi, lo, llwe, llval, cp0we, cp0addr, cp0data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_count  = 0;
      miss_count = 0;
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'h0;
      rst = 1'b0;
      setInputs(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

      // Reset asserted between edges: outputs clear without a clock edge.
      #2 rst = 1'b1;
      #1;
      checkWb("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Normal capture into the GPR write port.
      applyStimulus(6'b000000, 1'b0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkWb("capture", 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

      // MEM stalled, WB running: bubble. Same edge commits $5 into the model.
      applyStimulus(6'b011111, 1'b0, 5'd9, 1'b1, 32'h0000_1234, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB,
                    1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0077);
      checkWb("bubble", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      checkOutput("regfile_r5", tb_rf[5], 32'hDEADBEEF);

      // Full load including HI/LO and CP0.
      applyStimulus(6'b000000, 1'b0, 5'd7, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h1111_2222, 32'h3333_4444,
                    1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_FF01);
      checkWb("load", 5'd7, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h1111_2222, 32'h3333_4444,
              1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_FF01, 1'b0);

      // MEM and WB both stalled: hold for three edges despite new inputs.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'b111111, 1'b0, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                       1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
         checkWb($sformatf("hold%0d", i), 5'd7, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h1111_2222, 32'h3333_4444,
                 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_FF01, 1'b0);
      end

      // Non-monotone stall (MEM running, WB stalled) loads; $0 passes through.
      applyStimulus(6'b100000, 1'b0, 5'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkWb("r0_pass", 5'd0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

      // LL: WB write port after edge 1, architectural LLbit after edge 2.
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      checkWb("ll_e1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      checkWb("ll_e2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);

      // Flush with stall=0: bubble, and LLbit cleared although a set is pending.
      applyStimulus(6'b0, 1'b1, 5'd4, 1'b1, 32'h0000_0055, 1'b1, 32'h0000_0001, 32'h0000_0002,
                    1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0099);
      checkWb("flush", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

      // LL then SC: LLbit rises two edges after LL, falls two edges after SC.
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      checkWb("ll2_e1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkWb("ll2_e2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      checkWb("sc_e1", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      checkWb("sc_e2", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

      // Build up live state (LLbit=1, wb_wreg=1) and reset in mid-cycle.
      applyStimulus(6'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      applyStimulus(6'b0, 1'b0, 5'd6, 1'b1, 32'h0000_0066, 1'b1, 32'h6, 32'h7, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1);
      checkWb("pre_rst", 5'd6, 1'b1, 32'h0000_0066, 1'b1, 32'h6, 32'h7, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1, 1'b1);
      #3 rst = 1'b1;
      #1;
      checkWb("mid_rst", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      applyStimulus(6'b0, 1'b0, 5'd8, 1'b1, 32'h0000_0088, 1'b1, 32'h8, 32'h9, 1'b1, 1'b1, 1'b1, 5'd2, 32'h2);
      checkWb("rst_held", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      rst = 1'b0;
      applyStimulus(6'b0, 1'b0, 5'd8, 1'b1, 32'h0000_0088, 1'b1, 32'h8, 32'h9, 1'b1, 1'b1, 1'b1, 5'd2, 32'h2);
      checkWb("post_rst", 5'd8, 1'b1, 32'h0000_0088, 1'b1, 32'h8, 32'h9, 1'b1, 1'b1, 1'b1, 5'd2, 32'h2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM and WB stages of the 5-stage MIPS32 core.
- Outputs drive the register file write port (we/waddr/wdata), the HI/LO register write port and the CP0 write port.
- Owns the LLbit register used by LL/SC.
- Implements the core-wide stall/bubble/flush rules for the WB boundary.

Parameters:
- REG_ADDR_W, 5, GPR address width (matches the 32-entry register file)
- DATA_W, 32, GPR/HI/LO/CP0 data width
- CP0_ADDR_W, 5, CP0 register address width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- stall  in  6  stall vector from ctrl; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
- flush  in  1  exception flush from ctrl; synchronous
- mem_wd  in  REG_ADDR_W  destination GPR of the MEM-stage instruction
- mem_wreg  in  1  GPR write enable from MEM
- mem_wdata  in  DATA_W  GPR write data from MEM (loads already aligned/extended)
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DATA_W  each; HI and LO write values
- mem_llbit_we  in  1  LLbit write enable (LL sets, SC clears)
- mem_llbit_value  in  1  LLbit value to write
- mem_cp0_we  in  1  CP0 write enable (MTC0)
- mem_cp0_waddr  in  CP0_ADDR_W  CP0 register address
- mem_cp0_wdata  in  DATA_W  CP0 write data
- wb_wd, wb_wreg, wb_wdata  out  REG_ADDR_W/1/DATA_W  to register file waddr/we/wdata
- wb_whilo, wb_hi, wb_lo  out  1/DATA_W/DATA_W  to HI/LO register
- wb_llbit_we, wb_llbit_value  out  1/1  committed LLbit update, also used by MEM for forwarding
- wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  out  1/CP0_ADDR_W/DATA_W  to CP0
- llbit_o  out  1  current architectural LLbit

Behaviour:
- rst=1, asynchronous:
  - every wb_* output is 0 immediately and held at 0 while rst is high.
  - llbit_o is 0.
- Pipeline register update, one rising edge per step. Conditions are evaluated in priority order:
  1. flush=1: all wb_* outputs are loaded with 0 (bubble), regardless of stall.
  2. stall[4]=1 and stall[5]=0: MEM is stalled but WB proceeds. All wb_* are loaded with 0 (bubble), so no write occurs twice.
  3. stall[4]=0: all wb_* are loaded from the matching mem_* inputs; latency is exactly 1 cycle.
  4. stall[4]=1 and stall[5]=1: all wb_* hold their values.
- The stall vector is assumed monotone (stall[5]=1 implies stall[4]=1). The case stall[4]=0 with stall[5]=1 is treated as rule 3.
- wb_wreg=1 with wb_wd=0 is passed through unchanged; the register file suppresses writes to $0. No masking is done here.
- Data fields are captured even when their enable is 0; only enables are architecturally meaningful.
- LLbit register, in a sub-module:
  - Reset value 0.
  - On the rising edge, flush=1 writes 0 (an exception breaks the LL/SC sequence).
  - Otherwise, wb_llbit_we=1 writes wb_llbit_value.
  - Otherwise it holds.
  - llbit_o is the registered value, so it reflects a WB-stage update one cycle after that update is presented on wb_llbit_*.
- The LLbit sub-module samples the stage outputs present before the current edge. For example, an edge where flush=1 also clears LLbit even if wb_llbit_we=1 with value 1 is present.
- Reset mid-operation: the asynchronous clear takes effect immediately. The first capture happens at the first edge after rst falls, per the rules above.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package/def file: StallVec width 6 and stall bit indices (STALL_MEM=4, STALL_WB=5); ZeroWord; RegAddrBus/RegBus/RegNum widths; WriteEnable/WriteDisable; RstEnable=1'b1.
- Sub-module llbit_reg (clk, rst, flush, we, din, dout): reset-cleared 1-bit register, flush priority over we. It is instantiated once inside mem_wb_stage.

Test Plan:
- Reset: assert rst mid-cycle while wb_wreg=1 -> every output 0 immediately, with no clock edge required; llbit_o=0.
- Normal capture: stall=0, mem_wd=5, mem_wreg=1, mem_wdata=0xDEADBEEF -> next edge wb_wd=5, wb_wreg=1, wb_wdata=0xDEADBEEF. A following regfile read of $5 returns 0xDEADBEEF one cycle later.
- Bubble vs hold:
  - stall=6'b011111 with mem_wreg=1 -> next edge wb_wreg=0, wb_wdata=0.
  - stall=6'b111111 -> outputs held for 3 cycles unchanged.
- Flush priority: flush=1 with stall=0, mem_whilo=1, mem_hi=0x1 -> wb_whilo=0, wb_hi=0; flush also clears llbit_o from 1 to 0.
- LL/SC:
  - mem_llbit_we=1, value=1 -> wb_llbit_we=1 after edge 1, llbit_o=1 after edge 2.
  - Then mem_llbit_we=1, value=0 -> llbit_o=0 two edges later.
- $0 pass-through and CP0: mem_wd=0, mem_wreg=1 -> wb_wd=0, wb_wreg=1. mem_cp0_we=1, addr=12, data=0x0000FF01 -> wb_cp0_* equal after one edge.
